// File: rtl/sdprf16x22_fifo_ctrl.sv
// sdprf16x22_fifo_ctrl: FWFT FIFO sequencer for an external 16x22 SDP RAM with 1-cycle read.
// A 2-entry prefetch buffer hides the RAM read latency so one pop per cycle is sustained.
module sdprf16x22_fifo_ctrl #(
  parameter int DW       = 22,
  parameter int AW       = 4,
  parameter int AFULL_TH = 14
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr,
  output logic [DW-1:0] ram_data,
  output logic [AW-1:0] ram_wraddress,
  output logic          ram_wren,
  output logic [AW-1:0] ram_rdaddress,
  output logic          ram_rden,
  input  logic [DW-1:0] ram_q
);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] L_AFULL = (AW+1)'(AFULL_TH);

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_ram_cnt, r_count;
  logic          r_inflight, r_full, r_afull, r_ovf, r_udf;
  logic [1:0]    r_buf_cnt;
  logic [DW-1:0] r_buf0, r_buf1;

  logic          w_push, w_pop, w_issue;
  logic [1:0]    w_bp, w_buf_cnt_n;
  logic [AW:0]   w_ram_cnt_n, w_count_n;
  logic [DW-1:0] w_head, w_buf0_n, w_buf1_n;

  assign w_push      = wr_en & ~r_full & ~aclr;
  assign w_pop       = rd_en & (r_buf_cnt != 2'd0);
  // Issue only if the buffer can still absorb the word once it lands next cycle
  assign w_issue     = (r_ram_cnt != '0) &
                       (({1'b0, r_buf_cnt} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2);
  assign w_ram_cnt_n = r_ram_cnt + (AW+1)'(w_push) - (AW+1)'(w_issue);
  assign w_bp        = r_buf_cnt - {1'b0, w_pop};
  assign w_buf_cnt_n = w_bp + {1'b0, r_inflight};
  assign w_count_n   = w_ram_cnt_n + (AW+1)'(w_issue) + (AW+1)'(w_buf_cnt_n);
  assign w_head      = w_pop ? r_buf1 : r_buf0;
  assign w_buf0_n    = (r_inflight && w_bp == 2'd0) ? ram_q : w_head;
  assign w_buf1_n    = (r_inflight && w_bp == 2'd1) ? ram_q : r_buf1;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_buf_cnt  <= '0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_wptr     <= r_wptr + AW'(w_push);
      r_rptr     <= r_rptr + AW'(w_issue);
      r_ram_cnt  <= w_ram_cnt_n;
      r_count    <= w_count_n;
      r_inflight <= w_issue;
      r_full     <= w_count_n == L_DEPTH;
      r_afull    <= w_count_n >= L_AFULL;
      r_ovf      <= err_clr ? 1'b0 : r_ovf | (wr_en & r_full);
      r_udf      <= err_clr ? 1'b0 : r_udf | (rd_en & ~rd_valid);
      r_buf_cnt  <= w_buf_cnt_n;
      r_buf0     <= w_buf0_n;
      r_buf1     <= w_buf1_n;
    end
  end

  assign full          = r_full;
  assign almost_full   = r_afull;
  assign rd_valid      = r_buf_cnt != 2'd0;
  assign rd_data       = r_buf0;
  assign count         = r_count;
  assign ovf           = r_ovf;
  assign udf           = r_udf;
  assign ram_data      = wr_data;
  assign ram_wraddress = r_wptr;
  assign ram_wren      = w_push;
  assign ram_rdaddress = r_rptr;
  assign ram_rden      = w_issue;
endmodule

// File: tb/tb_sdprf16x22_fifo_ctrl.sv
// tb_sdprf16x22_fifo_ctrl: directed checks of the FWFT FIFO controller with a behavioural SDP RAM.
module tb_sdprf16x22_fifo_ctrl;
  logic        clock = 1'b0, aclr = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [21:0] wr_data = '0;
  logic        full, almost_full, rd_valid, ovf, udf, ram_wren, ram_rden;
  logic [21:0] rd_data, ram_data, ram_q;
  logic [4:0]  count;
  logic [3:0]  ram_wraddress, ram_rdaddress;
  logic [21:0] mem [16];
  int total = 0, bad = 0;

  sdprf16x22_fifo_ctrl dut (
    .clock(clock), .aclr(aclr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .ovf(ovf), .udf(udf), .err_clr(err_clr),
    .ram_data(ram_data), .ram_wraddress(ram_wraddress), .ram_wren(ram_wren),
    .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdaddress];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    chk("rst_flags", {28'd0, full, almost_full, ovf, udf}, 0);
    chk("rst_ram_en", {30'd0, ram_wren, ram_rden}, 0);
    aclr = 1'b0;
    // three pushes, first word visible three cycles after the first push
    wr_en = 1'b1;
    wr_data = 22'h1;
    step();
    wr_data = 22'h2;
    step();
    chk("lat_not_yet", 32'(rd_valid), 0);
    wr_data = 22'h3;
    step();
    wr_en = 1'b0;
    chk("lat_valid", 32'(rd_valid), 1);
    chk("lat_data", 32'(rd_data), 1);
    chk("lat_count", 32'(count), 3);
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("drain3_valid", 32'(rd_valid), 1);
      chk("drain3_data", 32'(rd_data), 32'(i));
      step();
    end
    rd_en = 1'b0;
    chk("drain3_empty", 32'(rd_valid), 0);
    chk("drain3_count", 32'(count), 0);
    // fill to 16, check almost_full / full thresholds
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 22'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 14));
      chk("fill_full", 32'(full), 32'(i == 16));
    end
    wr_data = 22'h3FFFF;
    #1;
    chk("ovf_no_wren", 32'(ram_wren), 0);
    step();
    wr_en = 1'b0;
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 16);
    // drain from full with no bubbles
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain16_valid", 32'(rd_valid), 1);
      chk("drain16_data", 32'(rd_data), 32'(i));
      step();
      if (i == 1) chk("full_release", 32'(full), 0);
    end
    rd_en = 1'b0;
    chk("drain16_empty", 32'(rd_valid), 0);
    chk("drain16_count", 32'(count), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    // streaming push+pop across pointer wrap
    for (int c = 0; c < 43; c++) begin
      wr_en = c < 40;
      wr_data = 22'(32'h100 + c);
      rd_en = c >= 3;
      if (c >= 3) begin
        chk("stream_valid", 32'(rd_valid), 1);
        chk("stream_data", 32'(rd_data), 32'(32'h100 + c - 3));
      end
      step();
      chk("stream_cnt_le3", 32'(count <= 5'd3), 1);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("stream_count", 32'(count), 0);
    chk("stream_noerr", {30'd0, ovf, udf}, 0);
    // underflow, clear, and clear-priority
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("udf_set", 32'(udf), 1);
    chk("udf_valid", 32'(rd_valid), 0);
    err_clr = 1'b1;
    step();
    chk("udf_clr", 32'(udf), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    err_clr = 1'b0;
    chk("udf_clr_prio", 32'(udf), 0);
    // async reset mid-stream
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_data = 22'(32'h200 + i);
      step();
    end
    wr_en = 1'b0;
    chk("pre_rst_count", 32'(count), 9);
    chk("pre_rst_data", 32'(rd_data), 32'h200);
    #2;
    aclr = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_rdata", 32'(rd_data), 0);
    chk("arst_flags", {28'd0, full, almost_full, ovf, udf}, 0);
    step();
    aclr = 1'b0;
    wr_en = 1'b1;
    wr_data = 22'h2AAAA;
    step();
    wr_en = 1'b0;
    step();
    chk("post_rst_early", 32'(rd_valid), 0);
    step();
    chk("post_rst_valid", 32'(rd_valid), 1);
    chk("post_rst_data", 32'(rd_data), 32'h2AAAA);
    chk("post_rst_count", 32'(count), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
